ddr_line_read_master: RTL and testbench

//   AXI4 full read master that fetches one display line per request from the DDR frame buffer into the video read FIFO.

---
 rtl/ddr_line_read_master.sv | 189 ++++++++++++++++++
 tb/tb_ddr_line_read_master.sv | 317 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ddr_line_read_master.sv
// ============================================================================
// ddr_line_read_master : AXI4 read master fetching one display line per request
// from the DDR frame buffer into the video read FIFO. Optional: AXI_RD_ERR_CNT_EN
// Revision: 1.0
// ============================================================================
`default_nettype none

module ddr_line_read_master #(
    parameter int                        AXI4_DATA_WIDTH = 128,
    parameter int                        AXI_ADDR_WIDTH  = 32,
    parameter logic [AXI_ADDR_WIDTH-1:0] FRAME_BASE_ADDR = '0,
    parameter int                        H_DISP          = 1280,
    parameter int                        V_DISP          = 720,
    parameter int                        BURST_LEN       = 16
) (
    input  logic                         M_AXI_ACLK,
    input  logic                         M_AXI_ARESETN,
    input  logic                         frame_start,
    input  logic                         burst_req_valid,
    output logic                         burst_req_ready,
    input  logic                         fifo_rst_n,
    input  logic                         fifo_full,
    output logic                         fifo_wr_en,
    output logic [AXI4_DATA_WIDTH-1:0]   fifo_wr_data,
    output logic [AXI_ADDR_WIDTH-1:0]    M_AXI_ARADDR,
    output logic [7:0]                   M_AXI_ARLEN,
    output logic [2:0]                   M_AXI_ARSIZE,
    output logic [1:0]                   M_AXI_ARBURST,
    output logic                         M_AXI_ARVALID,
    input  logic                         M_AXI_ARREADY,
    input  logic [AXI4_DATA_WIDTH-1:0]   M_AXI_RDATA,
    input  logic [1:0]                   M_AXI_RRESP,
    input  logic                         M_AXI_RLAST,
    input  logic                         M_AXI_RVALID,
    output logic                         M_AXI_RREADY
`ifdef AXI_RD_ERR_CNT_EN
    ,
    output logic [15:0]                  rd_err_cnt,
    output logic                         rd_len_err
`endif
);

    localparam int BEAT_BYTES      = AXI4_DATA_WIDTH / 8;
    localparam int LINE_BEATS      = H_DISP * 32 / AXI4_DATA_WIDTH;
    localparam int BURSTS_PER_LINE = LINE_BEATS / BURST_LEN;
    localparam int BURST_BYTES     = BURST_LEN * BEAT_BYTES;
    localparam int LINE_BYTES      = LINE_BEATS * BEAT_BYTES;
    localparam int LINE_IDX_W      = $clog2(V_DISP + 1);
    localparam int BURST_CNT_W     = $clog2(BURSTS_PER_LINE + 1);
    localparam int BEAT_CNT_W      = $clog2(BURST_LEN + 1);
    localparam int AW              = AXI_ADDR_WIDTH;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_ADDR = 2'd1,
        S_DATA = 2'd2
    } state_t;

    state_t                       state_q;
    logic [LINE_IDX_W-1:0]        line_idx_q;
    logic [BURST_CNT_W-1:0]       burst_cnt_q;
    logic [BEAT_CNT_W-1:0]        beat_cnt_q;
    logic                         frame_pend_q;
    logic [AW-1:0]                line_addr_q;
    logic [AW-1:0]                araddr_q;
    logic                         arvalid_q;
    logic                         fifo_wr_en_q;
    logic [AXI4_DATA_WIDTH-1:0]   fifo_wr_data_q;

    logic [LINE_IDX_W-1:0]        line_idx_sel_d;
    logic [AW-1:0]                line_addr_d;
    logic [AW-1:0]                araddr_next_d;
    logic                         rready_d;
    logic                         beat_d;
    logic                         line_wrap_d;

    // A frame_start coinciding with an accept must already fetch line 0
    assign line_idx_sel_d = frame_start ? '0 : line_idx_q;
    assign line_addr_d    = FRAME_BASE_ADDR + AW'(line_idx_sel_d) * AW'(LINE_BYTES);
    assign araddr_next_d  = line_addr_q + (AW'(burst_cnt_q) + AW'(1)) * AW'(BURST_BYTES);

    assign rready_d    = (state_q == S_DATA) && (!fifo_full || !fifo_rst_n);
    assign beat_d      = rready_d && M_AXI_RVALID;
    assign line_wrap_d = frame_pend_q || frame_start ||
                         (line_idx_q == LINE_IDX_W'(V_DISP - 1));

    assign burst_req_ready = (state_q == S_IDLE);
    assign M_AXI_RREADY    = rready_d;
    assign M_AXI_ARVALID   = arvalid_q;
    assign M_AXI_ARADDR    = araddr_q;
    assign M_AXI_ARLEN     = 8'(BURST_LEN - 1);
    assign M_AXI_ARSIZE    = 3'($clog2(BEAT_BYTES));
    assign M_AXI_ARBURST   = 2'b01;
    assign fifo_wr_en      = fifo_wr_en_q;
    assign fifo_wr_data    = fifo_wr_data_q;

    always_ff @(posedge M_AXI_ACLK or negedge M_AXI_ARESETN) begin
        if (!M_AXI_ARESETN) begin
            state_q        <= S_IDLE;
            line_idx_q     <= '0;
            burst_cnt_q    <= '0;
            beat_cnt_q     <= '0;
            frame_pend_q   <= 1'b0;
            line_addr_q    <= '0;
            araddr_q       <= '0;
            arvalid_q      <= 1'b0;
            fifo_wr_en_q   <= 1'b0;
            fifo_wr_data_q <= '0;
        end else begin
            fifo_wr_en_q <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (frame_start) begin
                        line_idx_q <= '0;
                    end
                    if (burst_req_valid) begin
                        line_addr_q <= line_addr_d;
                        araddr_q    <= line_addr_d;
                        arvalid_q   <= 1'b1;
                        burst_cnt_q <= '0;
                        state_q     <= S_ADDR;
                    end
                end
                S_ADDR: begin
                    if (frame_start) begin
                        frame_pend_q <= 1'b1;
                    end
                    if (M_AXI_ARREADY) begin
                        arvalid_q  <= 1'b0;
                        beat_cnt_q <= '0;
                        state_q    <= S_DATA;
                    end
                end
                S_DATA: begin
                    if (frame_start) begin
                        frame_pend_q <= 1'b1;
                    end
                    if (beat_d) begin
                        // Beats taken while the FIFO is in reset are drained, not written
                        fifo_wr_data_q <= M_AXI_RDATA;
                        fifo_wr_en_q   <= fifo_rst_n;
                        beat_cnt_q     <= beat_cnt_q + 1'b1;
                        if (M_AXI_RLAST) begin
                            if (burst_cnt_q != BURST_CNT_W'(BURSTS_PER_LINE - 1)) begin
                                burst_cnt_q <= burst_cnt_q + 1'b1;
                                araddr_q    <= araddr_next_d;
                                arvalid_q   <= 1'b1;
                                state_q     <= S_ADDR;
                            end else begin
                                frame_pend_q <= 1'b0;
                                line_idx_q   <= line_wrap_d ? '0 : line_idx_q + 1'b1;
                                state_q      <= S_IDLE;
                            end
                        end
                    end
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

`ifdef AXI_RD_ERR_CNT_EN
    logic [15:0] rd_err_cnt_q;
    logic        rd_len_err_q;

    always_ff @(posedge M_AXI_ACLK or negedge M_AXI_ARESETN) begin
        if (!M_AXI_ARESETN) begin
            rd_err_cnt_q <= '0;
            rd_len_err_q <= 1'b0;
        end else begin
            if (beat_d && M_AXI_RRESP[1] && (rd_err_cnt_q != 16'hFFFF)) begin
                rd_err_cnt_q <= rd_err_cnt_q + 16'd1;
            end
            if (beat_d && M_AXI_RLAST && (beat_cnt_q != BEAT_CNT_W'(BURST_LEN - 1))) begin
                rd_len_err_q <= 1'b1;
            end
        end
    end

    assign rd_err_cnt = rd_err_cnt_q;
    assign rd_len_err = rd_len_err_q;
`else
    logic w_unused;
    assign w_unused = ^{M_AXI_RRESP, beat_cnt_q};
`endif

endmodule

`default_nettype wire

// File: tb/tb_ddr_line_read_master.sv
// ============================================================================
// tb_ddr_line_read_master : directed bench with a small AXI read slave model
// and a FIFO write scoreboard. Revision: 1.0
// ============================================================================
`default_nettype none

module tb_ddr_line_read_master;

    localparam int          V_LINES = 6;
    localparam logic [31:0] BASE    = 32'h1000_0000;
    localparam int          LB      = 5120;
    localparam int          BB      = 256;

    logic         clk = 1'b0;
    logic         M_AXI_ARESETN = 1'b0;
    logic         frame_start = 1'b0;
    logic         burst_req_valid = 1'b0;
    logic         burst_req_ready;
    logic         fifo_rst_n = 1'b1;
    logic         fifo_full = 1'b0;
    logic         fifo_wr_en;
    logic [127:0] fifo_wr_data;
    logic [31:0]  M_AXI_ARADDR;
    logic [7:0]   M_AXI_ARLEN;
    logic [2:0]   M_AXI_ARSIZE;
    logic [1:0]   M_AXI_ARBURST;
    logic         M_AXI_ARVALID;
    logic         M_AXI_ARREADY = 1'b0;
    logic [127:0] M_AXI_RDATA = '0;
    logic [1:0]   M_AXI_RRESP = 2'b00;
    logic         M_AXI_RLAST = 1'b0;
    logic         M_AXI_RVALID = 1'b0;
    logic         M_AXI_RREADY;
`ifdef AXI_RD_ERR_CNT_EN
    logic [15:0]  rd_err_cnt;
    logic         rd_len_err;
`endif

    ddr_line_read_master #(
        .FRAME_BASE_ADDR (BASE),
        .V_DISP          (V_LINES)
    ) u_dut (
        .M_AXI_ACLK      (clk),
        .M_AXI_ARESETN   (M_AXI_ARESETN),
        .frame_start     (frame_start),
        .burst_req_valid (burst_req_valid),
        .burst_req_ready (burst_req_ready),
        .fifo_rst_n      (fifo_rst_n),
        .fifo_full       (fifo_full),
        .fifo_wr_en      (fifo_wr_en),
        .fifo_wr_data    (fifo_wr_data),
        .M_AXI_ARADDR    (M_AXI_ARADDR),
        .M_AXI_ARLEN     (M_AXI_ARLEN),
        .M_AXI_ARSIZE    (M_AXI_ARSIZE),
        .M_AXI_ARBURST   (M_AXI_ARBURST),
        .M_AXI_ARVALID   (M_AXI_ARVALID),
        .M_AXI_ARREADY   (M_AXI_ARREADY),
        .M_AXI_RDATA     (M_AXI_RDATA),
        .M_AXI_RRESP     (M_AXI_RRESP),
        .M_AXI_RLAST     (M_AXI_RLAST),
        .M_AXI_RVALID    (M_AXI_RVALID),
        .M_AXI_RREADY    (M_AXI_RREADY)
`ifdef AXI_RD_ERR_CNT_EN
        ,
        .rd_err_cnt      (rd_err_cnt),
        .rd_len_err      (rd_len_err)
`endif
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [127:0] pat(input int n);
        logic [31:0] v;
        v = n;
        return {v, ~v, v ^ 32'h5A5A_5A5A, v + 32'h1234_5678};
    endfunction

    // Slave model: inputs change on the falling edge, handshakes are judged 1ns later
    bit           burst_active = 1'b0;
    bit           arready_en   = 1'b1;
    bit           short_next   = 1'b0;
    bit           cur_short    = 1'b0;
    int           beat_idx     = 0;
    int           data_ctr     = 0;
    int           beats_total  = 0;
    int           wr_cnt       = 0;
    int           ar_cnt       = 0;
    int           err_left     = 0;
    logic [31:0]  ar_addr [$];
    logic [127:0] exp_q [$];

    always begin
        @(negedge clk);
        M_AXI_ARREADY = arready_en;
        M_AXI_RVALID  = burst_active;
        M_AXI_RDATA   = pat(data_ctr);
        M_AXI_RLAST   = burst_active && (beat_idx == (cur_short ? 14 : 15));
        M_AXI_RRESP   = (burst_active && err_left > 0) ? 2'b10 : 2'b00;
        #1;
        if (M_AXI_ARESETN) begin
            if (fifo_wr_en) begin
                wr_cnt++;
                if (exp_q.size() == 0) chk("wr_spurious", 1, 0);
                else                   chk("wr_data", fifo_wr_data, exp_q.pop_front());
            end
            if (M_AXI_RVALID && M_AXI_RREADY) begin
                if (fifo_rst_n) exp_q.push_back(M_AXI_RDATA);
                if (err_left > 0) err_left--;
                beats_total++;
                data_ctr++;
                if (M_AXI_RLAST) burst_active = 1'b0;
                else             beat_idx++;
            end
            if (M_AXI_ARVALID && M_AXI_ARREADY) begin
                chk("ar_single_outstanding", burst_active, 0);
                chk("arlen", M_AXI_ARLEN, 15);
                chk("arsize", M_AXI_ARSIZE, 4);
                chk("arburst", M_AXI_ARBURST, 1);
                ar_addr.push_back(M_AXI_ARADDR);
                ar_cnt++;
                burst_active = 1'b1;
                beat_idx     = 0;
                cur_short    = short_next;
                short_next   = 1'b0;
            end
        end
    end

    task automatic start_req(input logic fs);
        @(negedge clk);
        burst_req_valid = 1'b1;
        frame_start     = fs;
        #2;
        chk("req_ready", burst_req_ready, 1);
        @(negedge clk);
        burst_req_valid = 1'b0;
        frame_start     = 1'b0;
    endtask

    task automatic wait_idle(input string tag);
        int n = 0;
        do begin
            @(negedge clk);
            #2;
            n++;
        end while (!burst_req_ready && n < 3000);
        chk({tag, "_idle"}, burst_req_ready, 1);
    endtask

    task automatic check_line(input int a0, input int w0, input logic [31:0] exp_base,
                              input int exp_wr, input string tag);
        int bad = 0;
        chk({tag, "_ar_count"}, ar_cnt - a0, 20);
        chk({tag, "_wr_count"}, wr_cnt - w0, exp_wr);
        for (int k = 0; k < 20; k++) begin
            if (a0 + k >= ar_addr.size())          bad++;
            else if (ar_addr[a0 + k] !== exp_base + k * BB) bad++;
        end
        chk({tag, "_ar_addr_bad"}, bad, 0);
        if (a0 < ar_addr.size()) chk({tag, "_ar_first"}, ar_addr[a0], exp_base);
    endtask

    task automatic run_line(input logic fs, input logic [31:0] exp_base,
                            input int exp_wr, input string tag);
        int a0 = ar_cnt;
        int w0 = wr_cnt;
        start_req(fs);
        wait_idle(tag);
        check_line(a0, w0, exp_base, exp_wr, tag);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int a0, w0, b0, n, bad;
        logic [31:0] hold_addr;

        repeat (3) @(negedge clk);
        #2;
        chk("rst_req_ready", burst_req_ready, 1);
        chk("rst_arvalid", M_AXI_ARVALID, 0);
        chk("rst_araddr", M_AXI_ARADDR, 0);
        chk("rst_rready", M_AXI_RREADY, 0);
        chk("rst_wr_en", fifo_wr_en, 0);
        chk("rst_wr_data", fifo_wr_data, 0);
`ifdef AXI_RD_ERR_CNT_EN
        chk("rst_err_cnt", rd_err_cnt, 0);
        chk("rst_len_err", rd_len_err, 0);
`endif
        @(negedge clk);
        M_AXI_ARESETN = 1'b1;

        // Line 0 with frame_start on the accept cycle
        run_line(1'b1, BASE, 320, "t1");

        // Lines 1..5, then wrap back to line 0
        for (int l = 1; l < V_LINES; l++) run_line(1'b0, BASE + l * LB, 320, "t2_line");
        run_line(1'b0, BASE, 320, "t2_wrap");

        // ARADDR/ARVALID held while ARREADY is low (line 1)
        a0 = ar_cnt; w0 = wr_cnt;
        arready_en = 1'b0;
        start_req(1'b0);
        #2;
        hold_addr = M_AXI_ARADDR;
        chk("hold_addr_first", hold_addr, BASE + LB);
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            #2;
            chk("hold_arvalid", M_AXI_ARVALID, 1);
            chk("hold_araddr", M_AXI_ARADDR, hold_addr);
        end
        arready_en = 1'b1;
        wait_idle("hold");
        check_line(a0, w0, BASE + LB, 320, "hold");

        // FIFO full for 50 cycles mid-line (line 2)
        w0 = wr_cnt;
        fork
            run_line(1'b0, BASE + 2 * LB, 320, "t3");
            begin
                n = 0;
                do begin @(negedge clk); n++; end while (wr_cnt < w0 + 40 && n < 3000);
                bad = 0;
                for (int i = 0; i < 50; i++) begin
                    @(negedge clk);
                    fifo_full = 1'b1;
                    #2;
                    if (M_AXI_RREADY) bad++;
                end
                @(negedge clk);
                fifo_full = 1'b0;
                chk("t3_rready_during_full", bad, 0);
            end
        join

        // FIFO reset during beats 100..199 of line 3, with full also high
        b0 = beats_total;
        fork
            run_line(1'b0, BASE + 3 * LB, 220, "t4");
            begin
                n = 0;
                do begin @(negedge clk); n++; end while (beats_total < b0 + 100 && n < 3000);
                fifo_rst_n = 1'b0;
                fifo_full  = 1'b1;
                bad = 0;
                n = 0;
                do begin
                    #2;
                    if (M_AXI_RVALID && !M_AXI_RREADY) bad++;
                    @(negedge clk);
                    n++;
                end while (beats_total < b0 + 200 && n < 3000);
                fifo_rst_n = 1'b1;
                fifo_full  = 1'b0;
                chk("t4_drain_rready", bad, 0);
            end
        join
        run_line(1'b0, BASE + 4 * LB, 320, "t4_next");

        // frame_start during burst 5 of line 1
        run_line(1'b0, BASE + 5 * LB, 320, "t5_pre");
        run_line(1'b0, BASE, 320, "t5_l0");
        a0 = ar_cnt;
        fork
            run_line(1'b0, BASE + LB, 320, "t5");
            begin
                n = 0;
                do begin @(negedge clk); n++; end while (ar_cnt < a0 + 6 && n < 3000);
                frame_start = 1'b1;
                @(negedge clk);
                frame_start = 1'b0;
            end
        join
        run_line(1'b0, BASE, 320, "t5_after");
        run_line(1'b0, BASE + LB, 320, "t5_next");

        // frame_start alone while idle
        @(negedge clk);
        frame_start = 1'b1;
        @(negedge clk);
        frame_start = 1'b0;
        run_line(1'b0, BASE, 320, "fs_idle");

`ifdef AXI_RD_ERR_CNT_EN
        chk("t6_len_err_before", rd_len_err, 0);
        err_left   = 3;
        short_next = 1'b1;
        run_line(1'b0, BASE + LB, 319, "t6");
        chk("t6_err_cnt", rd_err_cnt, 3);
        chk("t6_len_err", rd_len_err, 1);
`endif

        repeat (3) @(negedge clk);
        chk("scoreboard_empty", exp_q.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire
